// File: rtl/gost89_ofb_scheduler.sv
// gost89_ofb_scheduler
//   Time-shares one gost89_ofb_encrypt core among NUM_CH independent OFB streams.
//   Requesters are granted round-robin. For each granted block the channel's key,
//   plaintext and feedback are held on the core ports for the whole operation.
//   The feedback is either the channel's fresh IV (i_ch_new_iv) or its saved OFB
//   state, and it is restored through the core IV port, so load_IV is always 1.
//   Ciphertext leaves tagged with its channel id.
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_ch_valid/o_ch_ready          per-channel block request / one-hot consume strobe
//   i_ch_new_iv, i_ch_iv           start a new message using the supplied IV
//   i_ch_data, i_ch_key            per-channel plaintext (64b) and key (256b)
//   o_out_*/i_out_ready            ciphertext stream with channel tag
//   o_err_valid, o_err_ch          1-cycle pulse: block dropped (no context) or core timeout
//   o_core_*/i_core_*              connection to the shared core
module gost89_ofb_scheduler #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_CH-1:0]     i_ch_valid,
  output logic [NUM_CH-1:0]     o_ch_ready,
  input  logic [NUM_CH-1:0]     i_ch_new_iv,
  input  logic [NUM_CH*64-1:0]  i_ch_data,
  input  logic [NUM_CH*64-1:0]  i_ch_iv,
  input  logic [NUM_CH*256-1:0] i_ch_key,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [63:0]           o_out_data,
  output logic [CH_W-1:0]       o_out_ch,
  output logic                  o_err_valid,
  output logic [CH_W-1:0]       o_err_ch,
  output logic                  o_core_reset,
  output logic                  o_core_load_data,
  output logic                  o_core_load_IV,
  output logic [63:0]           o_core_IV,
  output logic [63:0]           o_core_in,
  output logic [255:0]          o_core_key,
  input  logic [63:0]           i_core_out,
  input  logic                  i_core_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]        r_state;
  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   r_gch;
  logic [63:0]       r_data;
  logic [63:0]       r_iv;
  logic [255:0]      r_key;
  logic [CNT_W-1:0]  r_cnt;
  logic [63:0]       r_ctx [NUM_CH];
  logic [NUM_CH-1:0] r_ctx_valid;
  logic [63:0]       r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_err_valid;
  logic [CH_W-1:0]   r_err_ch;

  logic              w_found;
  logic [CH_W-1:0]   w_pick;
  logic [NUM_CH-1:0] w_ready;
  logic [63:0]       w_iv_sel;
  logic              w_no_ctx;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      int unsigned idx;
      idx = (32'(r_rr) + k) % NUM_CH;
      if (!w_found && i_ch_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_found) begin
      w_ready[w_pick] = 1'b1;
    end
  end

  assign w_iv_sel = i_ch_new_iv[w_pick] ? i_ch_iv[64*w_pick +: 64] : r_ctx[w_pick];
  // A continuation block with no saved feedback cannot be encrypted correctly.
  assign w_no_ctx = !i_ch_new_iv[w_pick] && !r_ctx_valid[w_pick];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr        <= CH_W'(NUM_CH - 1);
      r_gch       <= '0;
      r_data      <= '0;
      r_iv        <= '0;
      r_key       <= '0;
      r_cnt       <= '0;
      r_ctx_valid <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_err_valid <= 1'b0;
      r_err_ch    <= '0;
    end else begin
      r_err_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_rr   <= w_pick;
            r_gch  <= w_pick;
            r_data <= i_ch_data[64*w_pick +: 64];
            r_key  <= i_ch_key[256*w_pick +: 256];
            r_iv   <= w_iv_sel;
            if (w_no_ctx) begin
              r_err_valid <= 1'b1;
              r_err_ch    <= w_pick;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: r_state <= S_WAIT;
        // Core raises busy only after the load edge, so skip one cycle before polling it.
        S_WAIT: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (!i_core_busy) begin
            r_out_data         <= i_core_out;
            r_out_ch           <= r_gch;
            // Keystream = ciphertext ^ plaintext becomes the next OFB feedback.
            r_ctx[r_gch]       <= i_core_out ^ r_data;
            r_ctx_valid[r_gch] <= 1'b1;
            r_state            <= S_OUT;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_err_valid        <= 1'b1;
            r_err_ch           <= r_gch;
            r_ctx_valid[r_gch] <= 1'b0;
            r_state            <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ch_ready       = w_ready;
  assign o_out_valid      = (r_state == S_OUT);
  assign o_out_data       = r_out_data;
  assign o_out_ch         = r_out_ch;
  assign o_err_valid      = r_err_valid;
  assign o_err_ch         = r_err_ch;
  assign o_core_reset     = i_reset;
  assign o_core_load_data = (r_state == S_LOAD);
  assign o_core_load_IV   = 1'b1;
  assign o_core_IV        = r_iv;
  assign o_core_in        = r_data;
  assign o_core_key       = r_key;

endmodule
